dbg_port_arbiter: RTL and testbench

//  Shares the core's single debug port (req/gnt/rvalid, 15-bit word address) among NUM_REQ

---
 rtl/dbg_arb_pkg.sv | 13 +
 rtl/dbg_port_arbiter_rr_pick.sv | 33 +++
 rtl/dbg_port_arbiter.sv | 117 +++++++++++
 tb/tb_dbg_port_arbiter.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dbg_arb_pkg.sv
// Shared types for the debug-port arbiter.
// Transaction FSM states and the timeout response word.
package dbg_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [31:0] DBG_ERR_DATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/dbg_port_arbiter_rr_pick.sv
// Round-robin picker: first set request bit at or after ptr,
// wrapping modulo N.
module rr_pick #(
  parameter int N = 2,
  parameter int W = 1
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [W-1:0] idx,
  output logic         valid
);

  int         k;
  logic [W-1:0] kk;

  // Scan from the farthest offset down so the nearest hit wins.
  always_comb begin
    idx   = '0;
    valid = 1'b0;
    k     = 0;
    kk    = '0;
    for (int i = N - 1; i >= 0; i--) begin
      k = int'(ptr) + i;
      if (k >= N) k = k - N;
      kk = W'(k);
      if (req[kk]) begin
        idx   = kk;
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dbg_port_arbiter.sv
// Round-robin arbiter sharing the core debug port among
// NUM_REQ requesters, one transaction at a time, with timeout.
module dbg_port_arbiter
  import dbg_arb_pkg::*;
#(
  parameter int NUM_REQ     = 2,
  parameter int ADDR_WIDTH  = 15,
  parameter int DATA_WIDTH  = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                          clk_i,
  input  logic                          rstn_i,
  input  logic [NUM_REQ-1:0]            req_i,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr_i,
  input  logic [NUM_REQ-1:0]            req_we_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata_i,
  output logic [NUM_REQ-1:0]            req_gnt_o,
  output logic [NUM_REQ-1:0]            req_rvalid_o,
  output logic [DATA_WIDTH-1:0]         req_rdata_o,
  output logic                          req_err_o,
  output logic                          debug_req_o,
  output logic [ADDR_WIDTH-1:0]         debug_addr_o,
  output logic                          debug_we_o,
  output logic [DATA_WIDTH-1:0]         debug_wdata_o,
  input  logic                          debug_gnt_i,
  input  logic                          debug_rvalid_i,
  input  logic [DATA_WIDTH-1:0]         debug_rdata_i,
  output logic                          busy_o
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  state_t                  state;
  logic [IW-1:0]           winner;
  logic [IW-1:0]           ptr;
  logic [IW-1:0]           nxt_ptr;
  logic [IW-1:0]           pick;
  logic                    pick_ok;
  logic [TW-1:0]           timer;
  logic [ADDR_WIDTH-1:0]   addr;
  logic                    we;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [NUM_REQ-1:0]      sel;
  logic                    gnt_hit;
  logic                    resp_ok;
  logic                    expired;
  logic                    done;

  rr_pick #(
    .N (NUM_REQ),
    .W (IW)
  ) u_pick (
    .req   (req_i),
    .ptr   (ptr),
    .idx   (pick),
    .valid (pick_ok)
  );

  assign sel     = {{(NUM_REQ-1){1'b0}}, 1'b1} << winner;
  assign gnt_hit = (state == REQ) && debug_gnt_i;
  assign resp_ok = debug_rvalid_i && (gnt_hit || state == RESP);
  assign expired = (state == RESP) && !debug_rvalid_i
                && (timer == TW'(TIMEOUT_CYC));
  assign done    = resp_ok || expired;
  assign nxt_ptr = (winner == IW'(NUM_REQ - 1)) ? '0
                                                : winner + 1'b1;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state  <= IDLE;
      winner <= '0;
      ptr    <= '0;
      timer  <= '0;
      addr   <= '0;
      we     <= 1'b0;
      wdata  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (pick_ok) begin
            winner <= pick;
            addr   <= req_addr_i[int'(pick)*ADDR_WIDTH +: ADDR_WIDTH];
            we     <= req_we_i[pick];
            wdata  <= req_wdata_i[int'(pick)*DATA_WIDTH +: DATA_WIDTH];
            state  <= REQ;
          end
        end
        REQ: begin
          if (debug_gnt_i) begin
            ptr   <= nxt_ptr;
            timer <= '0;
            state <= debug_rvalid_i ? IDLE : RESP;
          end
        end
        RESP: begin
          if (done) state <= IDLE;
          else      timer <= timer + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign debug_req_o   = (state == REQ);
  assign debug_addr_o  = addr;
  assign debug_we_o    = we;
  assign debug_wdata_o = wdata;
  assign busy_o        = (state != IDLE);
  assign req_gnt_o     = gnt_hit ? sel : '0;
  assign req_rvalid_o  = done ? sel : '0;
  assign req_err_o     = expired;
  assign req_rdata_o   = expired ? DATA_WIDTH'(DBG_ERR_DATA)
                       : resp_ok ? debug_rdata_i
                       : '0;

endmodule

// File: tb/tb_dbg_port_arbiter.sv
// Directed table-driven bench for dbg_port_arbiter:
// 2-requester instance plus a 4-requester instance for wrap order.
module tb_dbg_port_arbiter;

  localparam int TO0 = 255;

  typedef struct {
    logic [1:0]  req;
    logic        we;
    logic [14:0] a0;
    logic [14:0] a1;
    logic [31:0] d0;
    logic [31:0] d1;
    int          gdly;
    int          rdly;
    logic [31:0] rdata;
    logic [1:0]  exp_sel;
    logic [14:0] exp_addr;
    logic [31:0] exp_wdata;
  } vec_t;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [1:0]  r_req = '0;
  logic [29:0] r_addr = '0;
  logic [1:0]  r_we = '0;
  logic [63:0] r_wdata = '0;
  logic [1:0]  gnt_o, rv_o;
  logic [31:0] rdata_o;
  logic        err_o, d_req, d_we, busy;
  logic [14:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_gnt = 1'b0, d_rv = 1'b0;
  logic [31:0] d_rdata = '0;

  logic [3:0]   q_req = '0;
  logic [59:0]  q_addr;
  logic [3:0]   q_we = '0;
  logic [127:0] q_wdata = '0;
  logic [3:0]   q_gnt_o, q_rv_o;
  logic [31:0]  q_rdata_o;
  logic         q_err_o, q_dreq, q_dwe, q_busy;
  logic [14:0]  q_daddr;
  logic [31:0]  q_dwdata;
  logic         q_gnt = 1'b0, q_rv = 1'b0;
  logic [31:0]  q_rdata = 32'h0000_0777;

  assign q_addr = {15'h0403, 15'h0402, 15'h0401, 15'h0400};

  dbg_port_arbiter #(
    .NUM_REQ(2), .ADDR_WIDTH(15), .DATA_WIDTH(32), .TIMEOUT_CYC(TO0)
  ) u0 (
    .clk_i(clk), .rstn_i(rstn),
    .req_i(r_req), .req_addr_i(r_addr), .req_we_i(r_we),
    .req_wdata_i(r_wdata),
    .req_gnt_o(gnt_o), .req_rvalid_o(rv_o), .req_rdata_o(rdata_o),
    .req_err_o(err_o),
    .debug_req_o(d_req), .debug_addr_o(d_addr), .debug_we_o(d_we),
    .debug_wdata_o(d_wdata),
    .debug_gnt_i(d_gnt), .debug_rvalid_i(d_rv), .debug_rdata_i(d_rdata),
    .busy_o(busy)
  );

  dbg_port_arbiter #(
    .NUM_REQ(4), .ADDR_WIDTH(15), .DATA_WIDTH(32), .TIMEOUT_CYC(8)
  ) u1 (
    .clk_i(clk), .rstn_i(rstn),
    .req_i(q_req), .req_addr_i(q_addr), .req_we_i(q_we),
    .req_wdata_i(q_wdata),
    .req_gnt_o(q_gnt_o), .req_rvalid_o(q_rv_o), .req_rdata_o(q_rdata_o),
    .req_err_o(q_err_o),
    .debug_req_o(q_dreq), .debug_addr_o(q_daddr), .debug_we_o(q_dwe),
    .debug_wdata_o(q_dwdata),
    .debug_gnt_i(q_gnt), .debug_rvalid_i(q_rv), .debug_rdata_i(q_rdata),
    .busy_o(q_busy)
  );

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic txn(input vec_t v);
    @(negedge clk);
    r_req = v.req; r_addr = {v.a1, v.a0}; r_we = {2{v.we}};
    r_wdata = {v.d1, v.d0}; d_gnt = 0; d_rv = 0; d_rdata = v.rdata;
    #1 chk("decide_idle", {busy, d_req}, 0);
    for (int c = 0; c < v.gdly; c++) begin
      @(negedge clk);
      #1 chk("req_hold", {d_req, gnt_o}, 3'b100);
    end
    @(negedge clk);
    d_gnt = 1; d_rv = (v.rdly == 0);
    #1;
    chk("gnt", gnt_o, v.exp_sel);
    chk("addr", d_addr, v.exp_addr);
    chk("we", d_we, v.we);
    chk("wdata", d_wdata, v.exp_wdata);
    if (v.rdly == 0) begin
      chk("rv_same", rv_o, v.exp_sel);
      chk("rdata_same", rdata_o, v.rdata);
    end else begin
      chk("no_rv_at_gnt", rv_o, 0);
    end
    r_req = 0;
    for (int c = 1; c < v.rdly; c++) begin
      @(negedge clk);
      d_gnt = 0; d_rv = 0;
      #1 chk("resp_wait", {d_req, gnt_o, rv_o}, 0);
    end
    if (v.rdly > 0) begin
      @(negedge clk);
      d_gnt = 0; d_rv = 1;
      #1;
      chk("rv", rv_o, v.exp_sel);
      chk("rdata", rdata_o, v.rdata);
      chk("err_req_drop", {err_o, d_req}, 0);
    end
    @(negedge clk);
    d_gnt = 0; d_rv = 0;
    #1 chk("busy_after", busy, 0);
  endtask

  task automatic txn4(input logic [3:0] rq, input logic [3:0] exp,
                      input logic [14:0] ea);
    @(negedge clk);
    q_req = rq;
    @(negedge clk);
    q_gnt = 1;
    #1;
    chk("q_gnt", q_gnt_o, exp);
    chk("q_addr", q_daddr, ea);
    q_req = 0;
    @(negedge clk);
    q_gnt = 0; q_rv = 1;
    #1 chk("q_rv", q_rv_o, exp);
    @(negedge clk);
    q_rv = 0;
  endtask

  vec_t tbl [10];
  vec_t v5;
  int   at;
  bit   found;

  initial begin
    tbl[0] = '{2'b11, 1'b1, 15'h0100, 15'h0200, 32'hA000_0000,
               32'hB000_0000, 0, 1, 32'h0, 2'b01, 15'h0100, 32'hA000_0000};
    tbl[1] = '{2'b11, 1'b1, 15'h0101, 15'h0201, 32'hA000_0001,
               32'hB000_0001, 1, 1, 32'h1, 2'b10, 15'h0201, 32'hB000_0001};
    tbl[2] = '{2'b11, 1'b1, 15'h0102, 15'h0202, 32'hA000_0002,
               32'hB000_0002, 0, 2, 32'h2, 2'b01, 15'h0102, 32'hA000_0002};
    tbl[3] = '{2'b11, 1'b1, 15'h0103, 15'h0203, 32'hA000_0003,
               32'hB000_0003, 2, 1, 32'h3, 2'b10, 15'h0203, 32'hB000_0003};
    tbl[4] = '{2'b11, 1'b1, 15'h0104, 15'h0204, 32'hA000_0004,
               32'hB000_0004, 0, 1, 32'h4, 2'b01, 15'h0104, 32'hA000_0004};
    tbl[5] = '{2'b11, 1'b1, 15'h0105, 15'h0205, 32'hA000_0005,
               32'hB000_0005, 1, 3, 32'h5, 2'b10, 15'h0205, 32'hB000_0005};
    tbl[6] = '{2'b11, 1'b1, 15'h0106, 15'h0206, 32'hA000_0006,
               32'hB000_0006, 0, 1, 32'h6, 2'b01, 15'h0106, 32'hA000_0006};
    tbl[7] = '{2'b11, 1'b1, 15'h0107, 15'h0207, 32'hA000_0007,
               32'hB000_0007, 0, 1, 32'h7, 2'b10, 15'h0207, 32'hB000_0007};
    tbl[8] = '{2'b01, 1'b0, 15'h0010, 15'h0000, 32'h0, 32'h0,
               2, 1, 32'h1234_5678, 2'b01, 15'h0010, 32'h0};
    tbl[9] = '{2'b10, 1'b0, 15'h0000, 15'h0333, 32'h0, 32'h5555_AAAA,
               0, 0, 32'hCAFE_F00D, 2'b10, 15'h0333, 32'h5555_AAAA};

    #1;
    chk("rst_ctl", {busy, d_req, gnt_o, rv_o, err_o}, 0);
    chk("rst_data", {rdata_o, d_wdata}, 0);
    chk("rst_addr", {d_addr, d_we, q_busy}, 0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;

    for (int i = 0; i < 10; i++) txn(tbl[i]);

    // Timeout: core grants but never answers.
    @(negedge clk);
    r_req = 2'b01; r_addr = {15'h0, 15'h0044}; r_we = 0;
    @(negedge clk);
    d_gnt = 1;
    #1 chk("to_gnt", gnt_o, 2'b01);
    r_req = 0;
    found = 0; at = 0;
    for (int c = 1; c <= TO0 + 40 && !found; c++) begin
      @(negedge clk);
      d_gnt = 0;
      #1;
      if (rv_o != 0) begin found = 1; at = c; end
    end
    chk("to_cycle", at, TO0 + 1);
    chk("to_rv", rv_o, 2'b01);
    chk("to_err", err_o, 1);
    chk("to_rdata", rdata_o, 32'hDEAD_BEEF);
    @(negedge clk);
    d_rv = 1;
    #1 chk("stray_rv", {rv_o, busy}, 0);
    @(negedge clk);
    d_rv = 0;

    // Reset while in RESP drops the transaction and the rr pointer.
    @(negedge clk);
    r_req = 2'b01; r_addr = {15'h0, 15'h0055};
    @(negedge clk);
    d_gnt = 1;
    #1 r_req = 0;
    @(negedge clk);
    d_gnt = 0;
    @(negedge clk);
    #1 chk("pre_rst_busy", busy, 1);
    rstn = 0; d_rv = 1; d_rdata = 32'h9999_9999;
    #1;
    chk("mid_rst_ctl", {busy, d_req, gnt_o, rv_o, err_o}, 0);
    chk("mid_rst_data", {rdata_o, d_wdata}, 0);
    chk("mid_rst_addr", {d_addr, d_we}, 0);
    @(negedge clk);
    rstn = 1; d_rv = 0;
    v5 = '{2'b11, 1'b0, 15'h0066, 15'h0077, 32'h0, 32'h0,
           0, 1, 32'h0BAD_F00D, 2'b01, 15'h0066, 32'h0};
    txn(v5);

    // Four requesters: pointer wrap.
    txn4(4'b1000, 4'b1000, 15'h0403);
    txn4(4'b1010, 4'b0010, 15'h0401);
    txn4(4'b1010, 4'b1000, 15'h0403);
    txn4(4'b1010, 4'b0010, 15'h0401);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
